// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared constants, state encoding and width helper for the FIR
//            tap-delay / serial-MAC datapath.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int c_n     = 21;
    localparam int c_nb    = 18;
    localparam int c_nbc   = 18;
    localparam int c_nbo   = 18;
    localparam int c_shift = 17;

    localparam int         c_state_w   = 2;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_mac    = 2'd1;
    localparam logic [1:0] c_st_out    = 2'd2;

    // Sum of n products of nb x nbc bits can never overflow this width.
    function automatic int acc_width(input int n, input int nb, input int nbc);
        return nb + nbc + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_serial_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_serial_mac_if
// Brief    : Window-in / sample-out bundle of the serial FIR MAC stage.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_serial_mac_if
    import fir_pkg::*;
#(
    parameter int N   = c_n,
    parameter int NB  = c_nb,
    parameter int NBC = c_nbc,
    parameter int NBO = c_nbo
) ();

    logic               i_valid;
    logic [N*NB-1:0]    i_data;
    logic [N*NBC-1:0]   i_coeff;
    logic               o_ready;
    logic               o_valid;
    logic [NBO-1:0]     o_data;
    logic               o_overrun;

    modport master (
        output i_valid, i_data, i_coeff,
        input  o_ready, o_valid, o_data, o_overrun
    );

    modport slave (
        input  i_valid, i_data, i_coeff,
        output o_ready, o_valid, o_data, o_overrun
    );

endinterface
`default_nettype wire

// File: rtl/fir_serial_mac_sat_round.sv
`default_nettype none
// ============================================================================
// Module   : sat_round
// Brief    : Combinational round-half-up arithmetic right shift followed by
//            saturation to a signed OUT_W-bit range.
// Revision : 1.0 - initial release
// ============================================================================
module sat_round #(
    parameter int IN_W  = 41,
    parameter int SHIFT = 17,
    parameter int OUT_W = 18
) (
    input  wire logic signed [IN_W-1:0]  i_value,
    output logic signed      [OUT_W-1:0] o_value
);

    // One guard bit above the input so adding the half-LSB cannot wrap.
    localparam logic signed [IN_W:0] c_half =
        {{(IN_W + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
    localparam logic signed [IN_W:0] c_max =
        {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] c_min =
        {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [IN_W:0] w_sum;
    logic signed [IN_W:0] w_shift;

    always_comb begin
        w_sum   = {i_value[IN_W-1], i_value} + c_half;
        w_shift = w_sum >>> SHIFT;
        if (w_shift > c_max) begin
            o_value = c_max[OUT_W-1:0];
        end else if (w_shift < c_min) begin
            o_value = c_min[OUT_W-1:0];
        end else begin
            o_value = w_shift[OUT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_serial_mac.sv
`default_nettype none
// ============================================================================
// Module   : fir_serial_mac
// Brief    : Time-multiplexed FIR MAC: snapshots an N-tap window, accumulates
//            N products through one multiplier, rounds/saturates one sample.
// Revision : 1.0 - initial release
// ============================================================================
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int N     = c_n,
    parameter int NB    = c_nb,
    parameter int NBC   = c_nbc,
    parameter int NBO   = c_nbo,
    parameter int SHIFT = c_shift
) (
    input  wire logic       i_clock,
    input  wire logic       i_reset,
    input  wire logic       i_enable,
    fir_serial_mac_if.slave bus
);

    localparam int c_acc_w  = acc_width(N, NB, NBC);
    localparam int c_prod_w = NB + NBC;
    localparam int c_idx_w  = $clog2(N);

    logic [c_state_w-1:0]        r_state;
    logic [c_state_w-1:0]        w_next_state;
    logic                        w_ready;
    logic                        w_mac;
    logic                        w_out;
    logic                        w_accept;
    logic                        w_last;

    logic signed [NB-1:0]        r_data  [N];
    logic signed [NBC-1:0]       r_coeff [N];
    logic [c_idx_w-1:0]          r_index;
    logic signed [c_acc_w-1:0]   r_acc;
    logic signed [c_prod_w-1:0]  w_prod;
    logic signed [NBO-1:0]       w_result;
    logic [NBO-1:0]              r_odata;
    logic                        r_ovalid;
    logic                        r_overrun;

    assign w_accept = i_enable & bus.i_valid & w_ready;
    assign w_last   = (r_index == c_idx_w'(N - 1));
    assign w_prod   = r_data[r_index] * r_coeff[r_index];

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= c_st_idle;
        end else if (i_enable) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_next_state = c_st_mac;
            c_st_mac:  if (w_last)   w_next_state = c_st_out;
            c_st_out:  w_next_state = w_accept ? c_st_mac : c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_ready = (r_state == c_st_idle) || (r_state == c_st_out);
        w_mac   = (r_state == c_st_mac);
        w_out   = (r_state == c_st_out);
    end

    // Snapshot registers carry no reset: they are only read after a load.
    always_ff @(posedge i_clock) begin
        if (w_accept) begin
            for (int k = 0; k < N; k++) begin
                r_data[k]  <= bus.i_data[k*NB +: NB];
                r_coeff[k] <= bus.i_coeff[k*NBC +: NBC];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_index <= '0;
            r_acc   <= '0;
        end else if (i_enable) begin
            if (w_accept) begin
                r_index <= '0;
                r_acc   <= '0;
            end else if (w_mac) begin
                r_index <= r_index + c_idx_w'(1);
                r_acc   <= r_acc + {{(c_acc_w - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
            end
        end
    end

    sat_round #(
        .IN_W  (c_acc_w),
        .SHIFT (SHIFT),
        .OUT_W (NBO)
    ) u_sat_round (
        .i_value (r_acc),
        .o_value (w_result)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_odata   <= '0;
            r_ovalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_enable) begin
            r_ovalid  <= w_out;
            r_overrun <= bus.i_valid & ~w_ready;
            if (w_out) begin
                r_odata <= w_result;
            end
        end
    end

    assign bus.o_ready   = w_ready;
    assign bus.o_valid   = r_ovalid;
    assign bus.o_data    = r_odata;
    assign bus.o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_serial_mac
// Brief    : Self-checking bench: cycle compare against a window-level model
//            plus directed vectors with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_serial_mac;
    import fir_pkg::*;

    localparam int N     = c_n;
    localparam int NB    = c_nb;
    localparam int NBO   = c_nbo;
    localparam int SHIFT = c_shift;

    typedef logic [N*NB-1:0] window_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    fir_serial_mac_if bus ();

    fir_serial_mac dut (
        .i_clock  (clk),
        .i_reset  (rst_n),
        .i_enable (en),
        .bus      (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic FIR output: dot product, round half up, clamp.
    function automatic logic [NBO-1:0] fir_out(input window_t d, input window_t c);
        longint sum = 0;
        longint r;
        longint vmax = (longint'(1) <<< (NBO - 1)) - 1;
        longint vmin = -(longint'(1) <<< (NBO - 1));
        for (int k = 0; k < N; k++) begin
            sum += longint'($signed(d[k*NB +: NB])) * longint'($signed(c[k*NB +: NB]));
        end
        r = (sum + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > vmax) r = vmax;
        if (r < vmin) r = vmin;
        return r[NBO-1:0];
    endfunction

    function automatic window_t pack_one(input int k, input logic [NB-1:0] v);
        window_t w = '0;
        w[k*NB +: NB] = v;
        return w;
    endfunction

    function automatic window_t pack_all(input logic [NB-1:0] v);
        window_t w;
        for (int k = 0; k < N; k++) w[k*NB +: NB] = v;
        return w;
    endfunction

    function automatic window_t rand_window();
        window_t w;
        for (int k = 0; k < N; k++) w[k*NB +: NB] = NB'($urandom);
        return w;
    endfunction

    // Model state describes the DUT after the next rising edge; it is compared
    // at the following falling edge, then advanced with the inputs now present.
    bit               m_on = 1'b0;
    int               m_busy;
    logic             m_valid;
    logic             m_over;
    logic [NBO-1:0]   m_data;
    bit               m_rdy;
    int               pend_cnt[$];
    logic [NBO-1:0]   pend_val[$];

    always @(negedge clk) begin
        if (m_on) begin
            check("o_valid",   64'(bus.o_valid),   64'(m_valid));
            check("o_ready",   64'(bus.o_ready),   64'(m_busy == 0));
            check("o_overrun", 64'(bus.o_overrun), 64'(m_over));
            check("o_data",    64'(bus.o_data),    64'(m_data));
        end
        if (!rst_n) begin
            m_on    = 1'b1;
            m_busy  = 0;
            m_valid = 1'b0;
            m_over  = 1'b0;
            m_data  = '0;
            pend_cnt.delete();
            pend_val.delete();
        end else if (en) begin
            m_rdy   = (m_busy == 0);
            m_valid = 1'b0;
            foreach (pend_cnt[i]) pend_cnt[i]--;
            if (pend_cnt.size() > 0 && pend_cnt[0] == 0) begin
                m_valid = 1'b1;
                m_data  = pend_val.pop_front();
                void'(pend_cnt.pop_front());
            end
            if (m_busy > 0) m_busy--;
            m_over = bus.i_valid && !m_rdy;
            if (bus.i_valid && m_rdy) begin
                m_busy = N;
                pend_cnt.push_back(N + 1);
                pend_val.push_back(fir_out(bus.i_data, bus.i_coeff));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input window_t d, input window_t c);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_coeff = c;
        tick();
        bus.i_valid = 1'b0;
        bus.i_data  = rand_window();
        bus.i_coeff = rand_window();
    endtask

    task automatic wait_valid(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.o_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_case(input string name, input window_t d, input window_t c,
                            input logic [NBO-1:0] exp);
        int lat;
        present(d, c);
        wait_valid(60, lat);
        check({name, " latency"}, 64'(lat), 64'(N + 1));
        check({name, " data"},    64'(bus.o_data), 64'(exp));
        tick();
    endtask

    initial begin
        int lat;
        int n_val;
        int n_ovr;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_coeff = '0;
        repeat (3) tick();
        check("reset o_ready",   64'(bus.o_ready),   64'd1);
        check("reset o_valid",   64'(bus.o_valid),   64'd0);
        check("reset o_data",    64'(bus.o_data),    64'd0);
        check("reset o_overrun", 64'(bus.o_overrun), 64'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        tick();

        run_case("impulse", pack_one(5, 18'h10000), pack_one(5, 18'h10000), 18'h08000);
        run_case("round up", pack_one(0, 18'h00001), pack_one(0, 18'h10000), 18'h00001);
        run_case("round neg", pack_one(0, 18'h3FFFF), pack_one(0, 18'h10000), 18'h00000);
        run_case("sat max", pack_all(18'h1FFFF), pack_all(18'h1FFFF), 18'h1FFFF);
        run_case("sat min", pack_all(18'h20000), pack_all(18'h1FFFF), 18'h20000);
        begin
            window_t d = rand_window();
            window_t c = rand_window();
            run_case("random", d, c, fir_out(d, c));
        end

        // Continuous offers: accepts on E0, E22, E44, E66 of a 70-edge run.
        n_val = 0;
        n_ovr = 0;
        bus.i_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            bus.i_data  = rand_window();
            bus.i_coeff = rand_window();
            tick();
            if (bus.o_valid === 1'b1)   n_val++;
            if (bus.o_overrun === 1'b1) n_ovr++;
        end
        bus.i_valid = 1'b0;
        check("b2b valid count",   64'(n_val), 64'd3);
        check("b2b overrun count", 64'(n_ovr), 64'd66);
        wait_valid(40, lat);
        check("b2b tail latency", 64'(lat), 64'd19);
        tick();

        // Stall 7 cycles mid-MAC and 7 cycles in OUT.
        present(pack_one(5, 18'h10000), pack_one(5, 18'h10000));
        repeat (5) tick();
        en = 1'b0;
        repeat (7) tick();
        en = 1'b1;
        repeat (16) tick();
        check("stall out ready", 64'(bus.o_ready), 64'd1);
        check("stall out valid", 64'(bus.o_valid), 64'd0);
        en = 1'b0;
        repeat (7) tick();
        check("stall held valid", 64'(bus.o_valid), 64'd0);
        en = 1'b1;
        tick();
        check("stall valid", 64'(bus.o_valid), 64'd1);
        check("stall data",  64'(bus.o_data),  64'h08000);
        en = 1'b0;
        repeat (3) tick();
        check("valid frozen", 64'(bus.o_valid), 64'd1);
        en = 1'b1;
        tick();
        check("valid one cycle", 64'(bus.o_valid), 64'd0);

        // Reset at MAC index 10, applied while the clock-enable is low.
        present(pack_all(18'h1FFFF), pack_all(18'h1FFFF));
        repeat (10) tick();
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        check("midreset o_data",  64'(bus.o_data),  64'd0);
        check("midreset o_valid", 64'(bus.o_valid), 64'd0);
        check("midreset o_ready", 64'(bus.o_ready), 64'd1);
        rst_n = 1'b1;
        en    = 1'b1;
        n_val = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.o_valid === 1'b1) n_val++;
        end
        check("no stale valid", 64'(n_val), 64'd0);
        run_case("after reset", pack_one(0, 18'h00001), pack_one(0, 18'h10000), 18'h00001);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
